// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO and MTHI/MTLO writes.
// Optional macro MULDIV_EARLY_TERM_EN: multiply leaves RUN once the remaining multiplier bits are zero.
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [5:0]            func,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    addend;
    logic            op_div;
    logic            neg_lo;
    logic            neg_hi;
    logic            dz;
`ifdef MULDIV_EARLY_TERM_EN
    logic [W-1:0]    mrem;
    logic [2*W-1:0]  mul_aligned;
`endif

    logic            is_mul;
    logic            is_div;
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;

    always_comb begin
        is_mul    = (func == F_MULT) || (func == F_MULTU);
        is_div    = (func == F_DIV)  || (func == F_DIVU);
        is_signed = (func == F_MULT) || (func == F_DIV);
        a_neg     = is_signed && data_a[W-1];
        b_neg     = is_signed && data_b[W-1];
        a_mag     = a_neg ? -data_a : data_a;
        b_mag     = b_neg ? -data_b : data_b;
    end

    // acc holds {partial product, unconsumed multiplier} or {remainder, dividend/quotient}
    logic [W:0]      mul_upper;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      div_upper;
    logic [W:0]      div_diff;
    logic            div_ge;
    logic [W-1:0]    div_rem;
    logic [2*W-1:0]  div_next;

    always_comb begin
        mul_upper = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, addend} : {(W+1){1'b0}});
        mul_next  = {mul_upper, acc[W-1:1]};
        div_upper = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_upper - {1'b0, addend};
        // remainder stays below the divisor, so the difference sign bit is an exact compare
        div_ge    = ~div_diff[W];
        div_rem   = div_ge ? div_diff[W-1:0] : div_upper[W-1:0];
        div_next  = {div_rem, acc[W-2:0], div_ge};
    end

`ifdef MULDIV_EARLY_TERM_EN
    always_comb begin
        mul_aligned = mul_next >> (LAST - count);
    end
`endif

    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;
    logic [W-1:0]    hi_fix;
    logic [W-1:0]    lo_fix;

    always_comb begin
        prod_fix = neg_lo ? -acc : acc;
        quo_fix  = neg_lo ? -acc[W-1:0] : acc[W-1:0];
        rem_fix  = neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];
        hi_fix   = op_div ? rem_fix : prod_fix[2*W-1:W];
        lo_fix   = op_div ? quo_fix : prod_fix[W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            acc      <= '0;
            addend   <= '0;
            op_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            dz       <= 1'b0;
`ifdef MULDIV_EARLY_TERM_EN
            mrem     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul || (is_div && data_b != '0)) begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            count  <= '0;
                            op_div <= is_div;
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg;
                            dz     <= 1'b0;
                            acc    <= {{W{1'b0}}, (is_div ? a_mag : b_mag)};
                            addend <= is_div ? b_mag : a_mag;
`ifdef MULDIV_EARLY_TERM_EN
                            mrem   <= b_mag;
`endif
                        end else if (is_div) begin
                            // divide by zero: FIX only delays done by one cycle, no stall raised
                            state <= FIX;
                            dz    <= 1'b1;
                        end else if (func == F_MTHI) begin
                            hi <= data_a;
                        end else if (func == F_MTLO) begin
                            lo <= data_a;
                        end
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (op_div) begin
                        acc <= div_next;
                        if (count == LAST) begin
                            state <= FIX;
                        end
                    end else begin
`ifdef MULDIV_EARLY_TERM_EN
                        mrem <= mrem >> 1;
                        if ((mrem >> 1) == '0) begin
                            acc   <= mul_aligned;
                            state <= FIX;
                        end else begin
                            acc <= mul_next;
                        end
`else
                        acc <= mul_next;
                        if (count == LAST) begin
                            state <= FIX;
                        end
`endif
                    end
                end
                FIX: begin
                    state    <= DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= dz;
                    if (!dz) begin
                        hi <= hi_fix;
                        lo <= lo_fix;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected HI/LO/div_zero/done-cycle,
// a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_sequencer;
    localparam int W = 32;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef MULDIV_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [5:0]    func;
    logic [W-1:0]  data_a;
    logic [W-1:0]  data_b;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    always #5 clock = ~clock;

    muldiv_sequencer #(.DATA_WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .func     (func),
        .data_a   (data_a),
        .data_b   (data_b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           due;
        string        name;
    } exp_t;

    exp_t scoreboard[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // done-cycle model: fixed W+1, or iterations up to the top set multiplier bit when early-terminating
    function automatic int mul_latency(input logic [W-1:0] b, input bit is_signed);
        logic [W-1:0] m;
        int iters;
        m = (is_signed && b[W-1]) ? -b : b;
        iters = 1;
        for (int i = 0; i < W; i++) begin
            if (m[i]) iters = i + 1;
        end
        return EARLY_TERM ? iters + 1 : W + 1;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (!reset && done) begin
            if (scoreboard.size() == 0) begin
                check_output("unexpected_done", 64'(done), 64'(0));
            end else begin
                e = scoreboard.pop_front();
                check_output({e.name, "_hi"},    64'(hi),       64'(e.hi));
                check_output({e.name, "_lo"},    64'(lo),       64'(e.lo));
                check_output({e.name, "_dz"},    64'(div_zero), 64'(e.dz));
                check_output({e.name, "_cycle"}, 64'(cycle),    64'(e.due));
            end
        end
    end

    task automatic issue_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                            input logic edz, input int lat, input string name);
        exp_t e;
        @(negedge clock);
        start  = 1'b1;
        func   = f;
        data_a = a;
        data_b = b;
        @(posedge clock);
        #1;
        if (push) begin
            e.hi   = ehi;
            e.lo   = elo;
            e.dz   = edz;
            e.due  = cycle + lat;
            e.name = name;
            scoreboard.push_back(e);
        end
        start  = 1'b0;
        data_a = ~a;
        data_b = ~b;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (scoreboard.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        if (scoreboard.size() != 0) begin
            check_output({name, "_timeout"}, 64'(scoreboard.size()), 64'(0));
            scoreboard.delete();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] ehi, input logic [W-1:0] elo,
                                  input logic edz, input int lat, input string name);
        issue_op(f, a, b, 1'b1, ehi, elo, edz, lat, name);
        if (!edz) check_output({name, "_busy"}, 64'(busy), 64'(1));
        wait_drain(name);
        check_output({name, "_done_drop"}, 64'(done), 64'(0));
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        func   = 6'h00;
        data_a = '0;
        data_b = '0;
        repeat (2) @(posedge clock);
        #1;
        check_output("rst_busy", 64'(busy),     64'(0));
        check_output("rst_done", 64'(done),     64'(0));
        check_output("rst_dz",   64'(div_zero), 64'(0));
        check_output("rst_hi",   64'(hi),       64'(0));
        check_output("rst_lo",   64'(lo),       64'(0));
        @(negedge clock);
        reset = 1'b0;

        apply_stimulus(F_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0,
                       mul_latency(32'd2, 1'b0), "multu_max_x2");
        apply_stimulus(F_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0,
                       mul_latency(32'd5, 1'b1), "mult_neg3x5");
        apply_stimulus(F_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, W + 1, "divu_7_2");
        apply_stimulus(F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W + 1, "div_neg7_2");
        apply_stimulus(F_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, W + 1, "div_7_neg2");
        apply_stimulus(F_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, 1'b0, W + 1, "div_neg7_neg2");
        apply_stimulus(F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, W + 1, "div_wrap");
        apply_stimulus(F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0,
                       mul_latency(32'h80000000, 1'b1), "mult_minsq");
        apply_stimulus(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0,
                       mul_latency(32'hFFFFFFFF, 1'b0), "multu_maxsq");
        apply_stimulus(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0,
                       mul_latency(32'hFFFFFFFF, 1'b1), "mult_neg1sq");
        apply_stimulus(F_DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, W + 1, "divu_max_16");
        apply_stimulus(F_DIVU, 32'd3, 32'd5, 32'd3, 32'd0, 1'b0, W + 1, "divu_3_5");

        // divide by zero keeps HI/LO, then the next done clears the flag
        issue_op(F_MTHI, 32'hAA, 32'h0, 1'b0, '0, '0, 1'b0, 0, "mthi_aa");
        issue_op(F_MTLO, 32'hBB, 32'h0, 1'b0, '0, '0, 1'b0, 0, "mtlo_bb");
        apply_stimulus(F_DIV, 32'd5, 32'd0, 32'hAA, 32'hBB, 1'b1, 1, "div_by_zero");
        apply_stimulus(F_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, W + 1, "divu_after_dz");

        // start while busy is ignored and HI/LO hold during RUN
        issue_op(F_MULTU, 32'd6, 32'h70000000, 1'b1, 32'h2, 32'hA0000000, 1'b0,
                 mul_latency(32'h70000000, 1'b0), "multu_busy");
        repeat (4) @(posedge clock);
        @(negedge clock);
        start  = 1'b1;
        func   = F_DIVU;
        data_a = 32'd100;
        data_b = 32'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        check_output("ignored_busy", 64'(busy), 64'(1));
        check_output("run_hi_hold",  64'(hi),   64'(1));
        check_output("run_lo_hold",  64'(lo),   64'(3));
        wait_drain("multu_busy");
        repeat (3) @(posedge clock);

        // reset mid-operation aborts without a result
        issue_op(F_MULTU, 32'd3, 32'h40000000, 1'b0, '0, '0, 1'b0, 0, "multu_abort");
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_output("abort_busy", 64'(busy), 64'(0));
        check_output("abort_done", 64'(done), 64'(0));
        check_output("abort_hi",   64'(hi),   64'(0));
        check_output("abort_lo",   64'(lo),   64'(0));
        @(negedge clock);
        reset = 1'b0;
        apply_stimulus(F_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0,
                       mul_latency(32'd5, 1'b1), "mult_after_reset");

        // MTHI/MTLO write in one cycle with no busy or done
        issue_op(F_MTHI, 32'h1234, 32'h0, 1'b0, '0, '0, 1'b0, 0, "mthi");
        check_output("mthi_busy", 64'(busy), 64'(0));
        check_output("mthi_hi",   64'(hi),   64'(32'h1234));
        issue_op(F_MTLO, 32'h5678, 32'h0, 1'b0, '0, '0, 1'b0, 0, "mtlo");
        check_output("mtlo_busy", 64'(busy), 64'(0));
        check_output("mtlo_lo",   64'(lo),   64'(32'h5678));
        check_output("mtlo_hi",   64'(hi),   64'(32'h1234));
        repeat (3) @(posedge clock);
        #1;
        check_output("mt_no_done", 64'(done), 64'(0));

        apply_stimulus(F_MULTU, 32'd9, 32'd1, 32'd0, 32'd9, 1'b0,
                       mul_latency(32'd1, 1'b0), "multu_9x1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
